conv_addr_gen: RTL

Parametrised address and control sequencer for a multi-channel 2-D convolution layer. On a `start` pulse it walks every output pixel of every output channel. For each pixel it issues one feature-map read and one weight read per kernel tap, across all input channels. Each tap carries accumulator framing flags plus the result write address for the downstream MAC/adder. It sits between the feature-map BRAM, the weight BRAM and the conv MAC/result BRAM. It supersedes the fixed single-channel conv1/conv2 controllers with stride, zero-padding, stall and a done handshake.

---
 rtl/conv_addr_gen.sv | 166 ++++++++++++++++
 1 files changed

// File: rtl/conv_addr_gen.sv
// Address/control sequencer for a multi-channel 2-D convolution layer.
// Walks oc, oy, ox, ic, ky, kx and emits one registered feature/weight tap per non-stalled cycle.
module conv_addr_gen #(
    parameter int IN_CH     = 6,
    parameter int OUT_CH    = 16,
    parameter int IN_W      = 12,
    parameter int IN_H      = 12,
    parameter int K_W       = 5,
    parameter int K_H       = 5,
    parameter int STRIDE    = 1,
    parameter int PAD       = 0,
    parameter int DRAIN_CYC = 3,
    parameter int ADDR_PIC  = 10,
    parameter int ADDR_W    = 12,
    parameter int ADDR_OUT  = 10
) (
    input  logic                clk,
    input  logic                rstn,
    input  logic                start,
    input  logic                stall,
    output logic                busy,
    output logic                done,
    output logic                tap_valid,
    output logic                ena_pic,
    output logic [ADDR_PIC-1:0] address_pic,
    output logic                pad,
    output logic                ena_w,
    output logic [ADDR_W-1:0]   addra_w,
    output logic                acc_first,
    output logic                acc_last,
    output logic [ADDR_OUT-1:0] addr_out
);

    localparam int OUT_W = (IN_W + 2 * PAD - K_W) / STRIDE + 1;
    localparam int OUT_H = (IN_H + 2 * PAD - K_H) / STRIDE + 1;

    // Handshake: start is a one-cycle request taken only in IDLE; stall freezes
    // the loop nest in RUN only; busy spans accepted start through the done cycle.
    typedef enum logic [1:0] {S_IDLE, S_RUN, S_DRAIN, S_DONE} state_t;
    state_t state;

    logic [15:0] oc, oy, ox, ic, ky, kx, drain_cnt;
    logic kx_end, ky_end, ic_end, ox_end, oy_end, oc_end, last_tap;
    logic signed [31:0] iy, ix;
    logic in_range;
    logic [ADDR_PIC-1:0] pic_addr;
    logic [ADDR_W-1:0]   w_addr;
    logic [ADDR_OUT-1:0] o_addr;

    function automatic logic signed [31:0] ext(input logic [15:0] v);
        return $signed({16'd0, v});
    endfunction

    always_comb begin
        kx_end   = (kx == 16'(K_W - 1));
        ky_end   = (ky == 16'(K_H - 1));
        ic_end   = (ic == 16'(IN_CH - 1));
        ox_end   = (ox == 16'(OUT_W - 1));
        oy_end   = (oy == 16'(OUT_H - 1));
        oc_end   = (oc == 16'(OUT_CH - 1));
        last_tap = kx_end && ky_end && ic_end && ox_end && oy_end && oc_end;
        // Signed so taps reaching into the left/top padding go negative.
        iy       = ext(oy) * STRIDE + ext(ky) - PAD;
        ix       = ext(ox) * STRIDE + ext(kx) - PAD;
        in_range = (iy >= 0) && (iy < IN_H) && (ix >= 0) && (ix < IN_W);
        pic_addr = ADDR_PIC'(ext(ic) * (IN_H * IN_W) + iy * IN_W + ix);
        w_addr   = ADDR_W'(((ext(oc) * IN_CH + ext(ic)) * K_H + ext(ky)) * K_W + ext(kx));
        o_addr   = ADDR_OUT'(ext(oc) * (OUT_H * OUT_W) + ext(oy) * OUT_W + ext(ox));
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            state       <= S_IDLE;
            oc          <= '0;
            oy          <= '0;
            ox          <= '0;
            ic          <= '0;
            ky          <= '0;
            kx          <= '0;
            drain_cnt   <= '0;
            busy        <= 1'b0;
            done        <= 1'b0;
            tap_valid   <= 1'b0;
            ena_pic     <= 1'b0;
            ena_w       <= 1'b0;
            pad         <= 1'b0;
            acc_first   <= 1'b0;
            acc_last    <= 1'b0;
            address_pic <= '0;
            addra_w     <= '0;
            addr_out    <= '0;
        end else begin
            done      <= 1'b0;
            tap_valid <= 1'b0;
            ena_pic   <= 1'b0;
            ena_w     <= 1'b0;
            pad       <= 1'b0;
            acc_first <= 1'b0;
            acc_last  <= 1'b0;
            case (state)
                S_IDLE: begin
                    if (start) begin
                        state <= S_RUN;
                        busy  <= 1'b1;
                    end
                end
                S_RUN: begin
                    if (!stall) begin
                        tap_valid   <= 1'b1;
                        ena_w       <= 1'b1;
                        ena_pic     <= in_range;
                        pad         <= !in_range;
                        address_pic <= in_range ? pic_addr : '0;
                        addra_w     <= w_addr;
                        addr_out    <= o_addr;
                        acc_first   <= (ic == 16'd0) && (ky == 16'd0) && (kx == 16'd0);
                        acc_last    <= ic_end && ky_end && kx_end;
                        // Odometer advance; the final tap wraps every counter back to 0.
                        if (!kx_end) kx <= kx + 16'd1;
                        else begin
                            kx <= '0;
                            if (!ky_end) ky <= ky + 16'd1;
                            else begin
                                ky <= '0;
                                if (!ic_end) ic <= ic + 16'd1;
                                else begin
                                    ic <= '0;
                                    if (!ox_end) ox <= ox + 16'd1;
                                    else begin
                                        ox <= '0;
                                        if (!oy_end) oy <= oy + 16'd1;
                                        else begin
                                            oy <= '0;
                                            oc <= oc_end ? 16'd0 : oc + 16'd1;
                                        end
                                    end
                                end
                            end
                        end
                        if (last_tap) begin
                            state     <= S_DRAIN;
                            drain_cnt <= '0;
                        end
                    end
                end
                S_DRAIN: begin
                    address_pic <= '0;
                    addra_w     <= '0;
                    addr_out    <= '0;
                    if (drain_cnt == 16'(DRAIN_CYC)) begin
                        state <= S_DONE;
                        done  <= 1'b1;
                    end else begin
                        drain_cnt <= drain_cnt + 16'd1;
                    end
                end
                S_DONE: begin
                    state <= S_IDLE;
                    busy  <= 1'b0;
                end
                default: state <= S_IDLE;
            endcase
        end
    end

endmodule
